// File: rtl/packet_serializer.sv
// Packet serializer: accepts one complete packet and emits its flits, one per
// valid/ready handshake, toward the router injection port. A stall watchdog
// abandons the packet if downstream blocks for too long.
//
// Packet layout on the flat port (MSB first):
//   [PKT_WIDTH-1]                 is_complete
//   [PKT_WIDTH-2 -: TAIL_WIDTH]   tail_index (number of flits, 1..MAX_FLITS)
//   [i*FLIT_WIDTH +: FLIT_WIDTH]  buffer[i]; flits are forwarded verbatim
module packet_serializer #(
    parameter int unsigned MAX_FLITS   = 8,
    parameter int unsigned STALL_LIMIT = 255,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned FLIT_WIDTH  = 32,
    localparam int unsigned TAIL_WIDTH = $clog2(MAX_FLITS + 2),
    localparam int unsigned BUF_WIDTH  = MAX_FLITS * FLIT_WIDTH,
    localparam int unsigned PKT_WIDTH  = 1 + TAIL_WIDTH + BUF_WIDTH
) (
    input  logic                   nocclk,
    input  logic                   rst_n,
    input  logic [PKT_WIDTH-1:0]   packet,
    input  logic                   packet_valid,
    output logic                   packet_ready,
    output logic [FLIT_WIDTH-1:0]  flit,
    output logic                   flit_valid,
    input  logic                   flit_ready,
    output logic                   busy,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] sent_count
);

    localparam int unsigned IdxW   = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
    localparam int unsigned StallW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam bit          StallEn = (STALL_LIMIT != 0);
    localparam logic [StallW-1:0]     StallLimitC = StallW'(STALL_LIMIT);
    localparam logic [TAIL_WIDTH-1:0] MaxTailC    = TAIL_WIDTH'(MAX_FLITS);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                               state_q;
    logic [MAX_FLITS-1:0][FLIT_WIDTH-1:0] buf_q;
    logic [IdxW-1:0]                      idx_q;
    logic [IdxW-1:0]                      last_q;
    logic [StallW-1:0]                    stall_q;

    logic                  in_complete;
    logic [TAIL_WIDTH-1:0] in_tail;
    logic                  in_legal;
    logic                  accept;
    logic                  stall_hit;

    // Decode the presented packet and the watchdog threshold
    always_comb begin
        in_complete = packet[PKT_WIDTH-1];
        in_tail     = packet[PKT_WIDTH-2 -: TAIL_WIDTH];
        in_legal    = in_complete && (in_tail != '0) && (in_tail <= MaxTailC);
        accept      = packet_valid && packet_ready;
        // The stall that would bring the counter to the limit triggers the abandon
        stall_hit   = StallEn && ((stall_q + 1'b1) == StallLimitC);
    end

    // Control FSM with registered outputs
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            buf_q        <= '0;
            idx_q        <= '0;
            last_q       <= '0;
            stall_q      <= '0;
            packet_ready <= 1'b1;
            flit         <= '0;
            flit_valid   <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            sent_count   <= '0;
        end else begin
            error <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        buf_q  <= packet[BUF_WIDTH-1:0];
                        idx_q  <= '0;
                        last_q <= IdxW'(in_tail - 1'b1);
                        if (in_legal) begin
                            state_q      <= StSend;
                            packet_ready <= 1'b0;
                            busy         <= 1'b1;
                            flit_valid   <= 1'b1;
                            flit         <= packet[FLIT_WIDTH-1:0];
                            stall_q      <= '0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    // flit_valid is always high here, so flit_ready alone means handshake
                    if (flit_ready) begin
                        stall_q <= '0;
                        if (idx_q == last_q) begin
                            state_q      <= StIdle;
                            packet_ready <= 1'b1;
                            busy         <= 1'b0;
                            flit_valid   <= 1'b0;
                            sent_count   <= sent_count + 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            flit  <= buf_q[idx_q + 1'b1];
                        end
                    end else if (stall_hit) begin
                        // Abandon: downstream reclaims the partial packet on its own
                        state_q      <= StIdle;
                        packet_ready <= 1'b1;
                        busy         <= 1'b0;
                        flit_valid   <= 1'b0;
                        error        <= 1'b1;
                        stall_q      <= '0;
                    end else if (StallEn) begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_serializer.sv
// Scoreboard bench for packet_serializer: stimulus pushes expected flits, a
// negedge monitor pops and compares on every handshake.
module tb_packet_serializer;

    localparam int unsigned MaxFlits   = 8;
    localparam int unsigned StallLimit = 4;
    localparam int unsigned CountW     = 16;
    localparam int unsigned FlitW      = 32;
    localparam int unsigned TailW      = $clog2(MaxFlits + 2);
    localparam int unsigned PktW       = 1 + TailW + MaxFlits * FlitW;

    logic              nocclk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PktW-1:0]   packet = '0;
    logic              packet_valid = 1'b0;
    logic              packet_ready;
    logic [FlitW-1:0]  flit;
    logic              flit_valid;
    logic              flit_ready = 1'b0;
    logic              busy;
    logic              error;
    logic [CountW-1:0] sent_count;

    packet_serializer #(
        .MAX_FLITS  (MaxFlits),
        .STALL_LIMIT(StallLimit),
        .COUNT_WIDTH(CountW),
        .FLIT_WIDTH (FlitW)
    ) dut (
        .nocclk      (nocclk),
        .rst_n       (rst_n),
        .packet      (packet),
        .packet_valid(packet_valid),
        .packet_ready(packet_ready),
        .flit        (flit),
        .flit_valid  (flit_valid),
        .flit_ready  (flit_ready),
        .busy        (busy),
        .error       (error),
        .sent_count  (sent_count)
    );

    always #5 nocclk = ~nocclk;

    int               tests = 0;
    int               fails = 0;
    int unsigned      cyc = 0;
    int               err_cnt = 0;
    logic [FlitW-1:0] exp_q[$];
    int unsigned      hs_q[$];

    always @(posedge nocclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: handshake compare, stall stability, error pulse count
    initial begin
        logic             prev_stall;
        logic [FlitW-1:0] prev_flit;
        prev_stall = 1'b0;
        prev_flit  = '0;
        forever begin
            @(negedge nocclk);
            if (error === 1'b1) err_cnt++;
            if (prev_stall && flit_valid === 1'b1) check("stall_stable", flit, prev_flit);
            if (flit_valid === 1'b1 && flit_ready === 1'b1) begin
                hs_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_flit: got %0h, expected none", flit);
                end else begin
                    check("flit", flit, exp_q.pop_front());
                end
            end
            prev_stall = (flit_valid === 1'b1) && (flit_ready !== 1'b1);
            prev_flit  = flit;
        end
    end

    function automatic logic [FlitW-1:0] mk_flit(input int tail, input int i, input int tag);
        logic [1:0]  t;
        logic [31:0] tg;
        logic [31:0] ix;
        tg = tag;
        ix = i;
        if (tail == 1)             t = 2'd3;  // SYSTEM
        else if (i == 0)           t = 2'd0;  // HEAD
        else if (i == tail - 1)    t = 2'd2;  // TAIL
        else                       t = 2'd1;  // BODY
        return {t, tg[5:0], ix[23:0]};
    endfunction

    function automatic logic [PktW-1:0] mk_pkt(input bit complete, input int tail, input int tag);
        logic [PktW-1:0] p;
        logic [31:0]     tl;
        p  = '0;
        tl = tail;
        for (int i = 0; i < MaxFlits; i++) p[i*FlitW +: FlitW] = mk_flit(tail, i, tag);
        p[PktW-1]         = complete;
        p[PktW-2 -: TailW] = tl[TailW-1:0];
        return p;
    endfunction

    task automatic push_exp(input int tail, input int n, input int tag);
        for (int i = 0; i < n; i++) exp_q.push_back(mk_flit(tail, i, tag));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge nocclk);
            #1;
        end
    endtask

    // Present a packet; acc_cyc is the cycle in which the first flit appears
    task automatic present(input logic [PktW-1:0] p, output int unsigned acc_cyc);
        bit ok;
        ok = 1'b0;
        packet       = p;
        packet_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge nocclk);
            if (packet_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge nocclk);
            #1;
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got packet_ready=0, expected 1 within 50 cycles");
        end
        packet_valid = 1'b0;
        acc_cyc      = cyc;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        tick(2);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned       a;
        int unsigned       b;
        int                e0;
        logic [CountW-1:0] exp_sent;
        logic [5:0]        pat;
        exp_sent = '0;

        // Reset state
        #12;
        check("rst_packet_ready", packet_ready, 1);
        check("rst_flit_valid", flit_valid, 0);
        check("rst_flit", flit, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_sent_count", sent_count, 0);
        @(posedge nocclk);
        #1;
        rst_n = 1'b1;
        tick(1);

        // 4-flit packet, no backpressure
        flit_ready = 1'b1;
        hs_q.delete();
        push_exp(4, 4, 1);
        present(mk_pkt(1'b1, 4, 1), a);
        check("t1_busy", busy, 1);
        check("t1_ready_low", packet_ready, 0);
        tick(3);
        check("t1_ready_still_low", packet_ready, 0);
        tick(1);
        exp_sent = exp_sent + 1'b1;
        check("t1_ready_back", packet_ready, 1);
        check("t1_sent_count", sent_count, exp_sent);
        check("t1_hs_count", hs_q.size(), 4);
        for (int i = 0; i < 4; i++) check("t1_hs_cycle", hs_q[i], a + i);
        wait_drain("t1_drain");

        // SYSTEM then 2-flit back-to-back: one bubble
        hs_q.delete();
        push_exp(1, 1, 2);
        push_exp(2, 2, 3);
        present(mk_pkt(1'b1, 1, 2), a);
        present(mk_pkt(1'b1, 2, 3), b);
        check("t2_bubble", b, a + 2);
        tick(3);
        exp_sent = exp_sent + 2'd2;
        check("t2_hs_count", hs_q.size(), 3);
        check("t2_hs0", hs_q[0], a);
        check("t2_hs1", hs_q[1], a + 2);
        check("t2_hs2", hs_q[2], a + 3);
        check("t2_sent_count", sent_count, exp_sent);
        wait_drain("t2_drain");

        // 3-flit packet, flit_ready 1,0,0,1,0,1
        hs_q.delete();
        e0  = err_cnt;
        pat = 6'b101001;
        push_exp(3, 3, 4);
        present(mk_pkt(1'b1, 3, 4), a);
        for (int i = 0; i < 6; i++) begin
            flit_ready = pat[i];
            tick(1);
        end
        flit_ready = 1'b1;
        tick(1);
        exp_sent = exp_sent + 1'b1;
        check("t3_hs_count", hs_q.size(), 3);
        check("t3_hs0", hs_q[0], a);
        check("t3_hs1", hs_q[1], a + 3);
        check("t3_hs2", hs_q[2], a + 5);
        check("t3_no_error", err_cnt - e0, 0);
        check("t3_sent_count", sent_count, exp_sent);
        wait_drain("t3_drain");

        // Three stalls (one short of the limit) then handshake: no abandon
        hs_q.delete();
        e0 = err_cnt;
        push_exp(2, 2, 5);
        present(mk_pkt(1'b1, 2, 5), a);
        flit_ready = 1'b0;
        tick(3);
        flit_ready = 1'b1;
        tick(3);
        exp_sent = exp_sent + 1'b1;
        check("t3b_hs0", hs_q[0], a + 3);
        check("t3b_no_error", err_cnt - e0, 0);
        check("t3b_sent_count", sent_count, exp_sent);
        wait_drain("t3b_drain");

        // Watchdog abandon after 4 stalled cycles
        e0 = err_cnt;
        push_exp(3, 1, 6);
        present(mk_pkt(1'b1, 3, 6), a);
        tick(1);
        flit_ready = 1'b0;
        tick(3);
        check("t4_valid_while_stalled", flit_valid, 1);
        check("t4_error_not_yet", error, 0);
        tick(1);
        check("t4_valid_dropped", flit_valid, 0);
        check("t4_error_pulse", error, 1);
        check("t4_ready", packet_ready, 1);
        check("t4_busy", busy, 0);
        tick(1);
        check("t4_error_cleared", error, 0);
        tick(1);
        check("t4_error_count", err_cnt - e0, 1);
        check("t4_sent_unchanged", sent_count, exp_sent);
        flit_ready = 1'b1;
        wait_drain("t4_drain");

        // Illegal packets: incomplete, tail 0, tail MAX+1
        hs_q.delete();
        for (int k = 0; k < 3; k++) begin
            e0 = err_cnt;
            case (k)
                0:       present(mk_pkt(1'b0, 4, 9), a);
                1:       present(mk_pkt(1'b1, 0, 9), a);
                default: present(mk_pkt(1'b1, MaxFlits + 1, 9), a);
            endcase
            check("t5_no_valid", flit_valid, 0);
            tick(3);
            check("t5_error_count", err_cnt - e0, 1);
            check("t5_sent_unchanged", sent_count, exp_sent);
        end
        check("t5_no_flits", hs_q.size(), 0);

        // Reset during the second flit
        hs_q.delete();
        push_exp(4, 1, 7);
        present(mk_pkt(1'b1, 4, 7), a);
        tick(1);
        rst_n = 1'b0;
        #1;
        exp_sent = '0;
        check("t6_valid_low", flit_valid, 0);
        check("t6_ready_high", packet_ready, 1);
        check("t6_sent_zero", sent_count, exp_sent);
        check("t6_busy_low", busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("t6_one_flit", hs_q.size(), 1);
        check("t6_queue_empty", exp_q.size(), 0);
        push_exp(2, 2, 8);
        present(mk_pkt(1'b1, 2, 8), a);
        wait_drain("t6_drain");
        exp_sent = exp_sent + 1'b1;
        check("t6_sent_after", sent_count, exp_sent);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
